// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the sequenced ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIVU = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GTU  = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_DBZ   = 4;
  localparam int FLG_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// done_o pulses on the final step; lo_o/hi_o show that step's outcome in the same cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Multiply: conditionally add multiplicand into the high half, then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
    // Divide: shift remainder/quotient left, keep the trial subtraction if no borrow.
    div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff   = div_rem_sh - {1'b0, b_q};
    div_next   = div_diff[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    acc_d = is_div_q ? div_next : mul_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= {{WIDTH{1'b0}}, a_i};
      b_q      <= b_i;
      is_div_q <= is_div_i;
      busy_q   <= 1'b1;
      cnt_q    <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign lo_o   = acc_d[WIDTH-1:0];
  assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Handshaked 16-op ALU: single-cycle datapath plus iterative mul/div, with result flags.
// One transaction in flight; accept only in IDLE, result held in DONE until out_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             op_is_mul_q;
  logic [WIDTH-1:0] result_q;
  logic [FLG_W-1:0] flags_q;

  logic [SH_W-1:0]  amt, neg_amt;
  logic [WIDTH:0]   add_w, shl_w, shr_w;
  logic [WIDTH-1:0] sub_res, sc_res;
  logic             sc_carry, sc_ovf, sc_dbz;
  logic [FLG_W-1:0] sc_flags, md_flags;
  logic             is_iter, md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  always_comb begin
    amt     = b[SH_W-1:0];
    neg_amt = -amt;
    add_w   = {1'b0, a} + {1'b0, b};
    sub_res = a - b;
    // Extra bit on the shifted-out side captures the last bit lost (0 when amt is 0).
    shl_w   = {1'b0, a} << amt;
    shr_w   = {a, 1'b0} >> amt;
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dbz   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        sc_res   = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = sub_res;
        sc_carry = (a >= b);
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL:  sc_res = '0;
      OP_DIVU: begin
        sc_res = '1;
        sc_dbz = 1'b1;
      end
      OP_SHL: begin
        sc_res   = shl_w[WIDTH-1:0];
        sc_carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res   = shr_w[WIDTH:1];
        sc_carry = shr_w[0];
      end
      // Rotate by 0 ORs a with itself, so no special case is needed.
      OP_ROL:  sc_res = (a << amt) | (a >> neg_amt);
      OP_ROR:  sc_res = (a >> amt) | (a << neg_amt);
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_NAND: sc_res = ~(a & b);
      OP_XNOR: sc_res = ~(a ^ b);
      OP_GTU:  sc_res = WIDTH'(a > b);
      OP_EQ:   sc_res = WIDTH'(a == b);
      default: sc_res = '0;
    endcase

    sc_flags            = '0;
    sc_flags[FLG_ZERO]  = (sc_res == '0);
    sc_flags[FLG_NEG]   = sc_res[WIDTH-1];
    sc_flags[FLG_CARRY] = sc_carry;
    sc_flags[FLG_OVF]   = sc_ovf;
    sc_flags[FLG_DBZ]   = sc_dbz;

    md_flags            = '0;
    md_flags[FLG_ZERO]  = (md_lo == '0);
    md_flags[FLG_NEG]   = md_lo[WIDTH-1];
    md_flags[FLG_OVF]   = op_is_mul_q && (md_hi != '0);
  end

  // Divide by zero is resolved by the single-cycle path instead of iterating.
  assign is_iter  = is_muldiv_op(alu_op) && !((alu_op == OP_DIVU) && (b == '0));
  assign md_start = (state_q == IDLE) && in_valid && is_iter;

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .is_div_i (alu_op == OP_DIVU),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .lo_o     (md_lo),
    .hi_o     (md_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_is_mul_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_iter) begin
              op_is_mul_q <= (alu_op == OP_MUL);
              state_q     <= BUSY;
            end else begin
              result_q    <= sc_res;
              flags_q     <= sc_flags;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        BUSY: begin
          if (md_done) begin
            result_q    <= md_lo;
            flags_q     <= md_flags;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed checks of alu_seq at WIDTH=32: results, flags, latency, hold and reset abort.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure accept-to-out_valid latency, check result/flags, then drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_res,
                        input logic [4:0] exp_flg, input int exp_lat);
    int lat;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    alu_op   = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 32'hdeadbeef;
    b        = 32'h00000000;
    alu_op   = 4'hF;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flags"}, {27'd0, flags}, {27'd0, exp_flg});
    $display("op %s: a=%h b=%h result=%h flags=%b latency=%0d", tag, av, bv, result, flags, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drain_ovalid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    alu_op    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.flags", {27'd0, flags}, 32'd0);

    // flags = {dbz, ovf, carry, neg, zero}
    run_op("ADD_wrap",  4'h0, 32'hffffffff, 32'h00000001, 32'h00000000, 5'b00101, 1);
    run_op("SUB_ovf",   4'h1, 32'h7fffffff, 32'hffffffff, 32'h80000000, 5'b01010, 1);
    run_op("SUB_eq",    4'h1, 32'h00000009, 32'h00000009, 32'h00000000, 5'b00101, 1);
    run_op("MUL_ovf",   4'h2, 32'h00010000, 32'h00010000, 32'h00000000, 5'b01001, 33);
    run_op("MUL_small", 4'h2, 32'h00001234, 32'h00000010, 32'h00012340, 5'b00000, 33);
    run_op("DIVU_64_7", 4'h3, 32'd64,       32'd7,        32'd9,        5'b00000, 33);
    run_op("DIVU_big",  4'h3, 32'hffffffff, 32'h00000010, 32'h0fffffff, 5'b00000, 33);
    run_op("DIVU_dbz",  4'h3, 32'd5,        32'd0,        32'hffffffff, 5'b10010, 1);
    run_op("ROL_4",     4'h6, 32'h80000001, 32'd4,        32'h00000018, 5'b00000, 1);
    run_op("ROR_1",     4'h7, 32'h00000001, 32'd1,        32'h80000000, 5'b00010, 1);
    run_op("ROL_0",     4'h6, 32'h12345678, 32'd0,        32'h12345678, 5'b00000, 1);
    run_op("SHR_0",     4'h5, 32'h0000000f, 32'd0,        32'h0000000f, 5'b00000, 1);
    run_op("SHR_2",     4'h5, 32'h0000000f, 32'd2,        32'h00000003, 5'b00100, 1);
    run_op("SHL_1",     4'h4, 32'h80000001, 32'd1,        32'h00000002, 5'b00100, 1);
    run_op("AND",       4'h8, 32'hff00ff00, 32'h0ff00ff0, 32'h0f000f00, 5'b00000, 1);
    run_op("OR",        4'h9, 32'hff00ff00, 32'h0ff00ff0, 32'hfff0fff0, 5'b00010, 1);
    run_op("XOR",       4'hA, 32'hff00ff00, 32'h0ff00ff0, 32'hf0f0f0f0, 5'b00010, 1);
    run_op("NOR",       4'hB, 32'h00000000, 32'h00000000, 32'hffffffff, 5'b00010, 1);
    run_op("NAND",      4'hC, 32'hffffffff, 32'hffffffff, 32'h00000000, 5'b00001, 1);
    run_op("XNOR",      4'hD, 32'h0000ffff, 32'h00000000, 32'hffff0000, 5'b00010, 1);
    run_op("GTU",       4'hE, 32'h80000000, 32'h00000001, 32'h00000001, 5'b00000, 1);
    run_op("EQ_no",     4'hF, 32'h00000007, 32'h00000008, 32'h00000000, 5'b00001, 1);

    // Hold in DONE with out_ready low; a competing request must be ignored.
    alu_op   = 4'h0;
    a        = 32'd3;
    b        = 32'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    alu_op = 4'h1;
    a      = 32'd100;
    b      = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("hold.out_valid", {31'd0, out_valid}, 32'd1);
      check("hold.in_ready", {31'd0, in_ready}, 32'd0);
      check("hold.result", result, 32'd7);
      check("hold.flags", {27'd0, flags}, 32'd0);
      $display("hold cycle %0d: result=%h flags=%b in_ready=%b", i, result, flags, in_ready);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold.drain_ovalid", {31'd0, out_valid}, 32'd0);
    check("hold.drain_iready", {31'd0, in_ready}, 32'd1);

    // Reset during BUSY drops the pending multiply.
    alu_op   = 4'h2;
    a        = 32'd3;
    b        = 32'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort.busy_ovalid", {31'd0, out_valid}, 32'd0);
    check("abort.busy_iready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.out_valid", {31'd0, out_valid}, 32'd0);
    check("abort.in_ready", {31'd0, in_ready}, 32'd1);
    check("abort.result", result, 32'd0);
    check("abort.flags", {27'd0, flags}, 32'd0);
    $display("abort: out_valid=%b in_ready=%b result=%h", out_valid, in_ready, result);
    repeat (40) @(posedge clk);
    #1;
    check("abort.no_stale_ovalid", {31'd0, out_valid}, 32'd0);
    check("abort.no_stale_result", result, 32'd0);
    run_op("ADD_after", 4'h0, 32'd2, 32'd3, 32'd5, 5'b00000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
